// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and default baud divisor.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RX,
    STOP_CHK
  } rx_state_t;

  localparam int FRAME_BITS       = 10;
  localparam int DATA_BITS        = 8;
  localparam int CNT_W            = 16;
  // 50 MHz system clock at 19200 baud
  localparam int DEFAULT_BAUD_DIV = 2604;

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Parallel-side and line-side signals of the UART receive engine.
interface uart_rx_fsm_if;

  logic                           start_edge;
  logic                           rx_synch;
  logic                           clr_rdy;
  logic [uart_pkg::DATA_BITS-1:0] rx_data;
  logic                           rdy;
  logic                           framing_err;
  logic                           busy;

  // master: upstream edge detector plus consumer; slave: the receiver itself
  modport master (
    output start_edge, rx_synch, clr_rdy,
    input  rx_data, rdy, framing_err, busy
  );

  modport slave (
    input  start_edge, rx_synch, clr_rdy,
    output rx_data, rdy, framing_err, busy
  );

endinterface

// File: rtl/uart_rx_fsm_baud_cnt.sv
// Loadable down-counter that parks at zero; zero flags the count-expired point.
module baud_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/uart_rx_fsm.sv
// 8N1 receive engine: triggered by an upstream falling-edge pulse, samples the
// synchronized line at mid-bit and presents the byte with sticky rdy/framing_err.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fsm_if.slave   rx_if
);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       LAST_IDX  = 4'(FRAME_BITS - 1);

  rx_state_t              state_reg,   state_next;
  logic [3:0]             bit_idx_reg, bit_idx_next;
  logic [DATA_BITS:0]     sr_reg,      sr_next;
  logic [DATA_BITS-1:0]   rx_data_reg, rx_data_next;
  logic                   rdy_reg,     rdy_next;
  logic                   ferr_reg,    ferr_next;
  logic                   busy_reg,    busy_next;

  logic                   cnt_load;
  logic [CNT_W-1:0]       cnt_load_val;
  logic                   cnt_zero;

  baud_cnt #(.W(CNT_W)) u_baud_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_idx_reg <= '0;
      sr_reg      <= '0;
      rx_data_reg <= '0;
      rdy_reg     <= 1'b0;
      ferr_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_idx_reg <= bit_idx_next;
      sr_reg      <= sr_next;
      rx_data_reg <= rx_data_next;
      rdy_reg     <= rdy_next;
      ferr_reg    <= ferr_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    sr_next      = sr_reg;
    rx_data_next = rx_data_reg;
    rdy_next     = rdy_reg;
    ferr_next    = ferr_reg;
    cnt_load     = 1'b0;
    cnt_load_val = HALF_LOAD;

    // Acknowledge is applied first so a same-cycle commit overrides it
    if (rx_if.clr_rdy) begin
      rdy_next  = 1'b0;
      ferr_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (rx_if.start_edge) begin
          state_next   = RX;
          cnt_load     = 1'b1;
          cnt_load_val = HALF_LOAD;
          bit_idx_next = '0;
          ferr_next    = 1'b0;
        end
      end

      RX: begin
        if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = BIT_LOAD;
          bit_idx_next = bit_idx_reg + 4'd1;
          if (bit_idx_reg == '0) begin
            if (rx_if.rx_synch) begin
              state_next = IDLE;
            end
          end else begin
            // Data bits and the stop bit all shift in; stop ends up in the MSB
            sr_next = {rx_if.rx_synch, sr_reg[DATA_BITS:1]};
            if (bit_idx_reg == LAST_IDX) begin
              state_next = STOP_CHK;
            end
          end
        end
      end

      STOP_CHK: begin
        if (sr_reg[DATA_BITS]) begin
          rx_data_next = sr_reg[DATA_BITS-1:0];
          rdy_next     = 1'b1;
        end else begin
          ferr_next    = 1'b1;
        end
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign rx_if.rx_data     = rx_data_reg;
  assign rx_if.rdy         = rdy_reg;
  assign rx_if.framing_err = ferr_reg;
  assign rx_if.busy        = busy_reg;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm at 16 clocks per bit, with immediate-assertion checks.
module tb_uart_rx_fsm;

  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst;
  logic line_prev;
  int   passed = 0;
  int   fails  = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  uart_rx_fsm_if rx_if ();

  uart_rx_fsm #(.BAUD_DIV(BD)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_if (rx_if)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Hold line level b for n clock edges; the upstream detector pulse fires on a 1->0 change
  task automatic hold_bit(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      rx_if.start_edge = (i == 0) && line_prev && !b;
      rx_if.rx_synch   = b;
      @(posedge clk);
      #1;
    end
    line_prev        = b;
    rx_if.start_edge = 1'b0;
  endtask

  // Drive a frame up to and including the stop-bit sample edge (T+153)
  task automatic frame_body(input logic [7:0] d, input logic stop);
    hold_bit(1'b0, 1);
    check("busy_after_start", {15'b0, rx_if.busy}, 16'h0001);
    hold_bit(1'b0, 15);
    for (int k = 0; k < 8; k++) hold_bit(d[k], BD);
    hold_bit(stop, 10);
  endtask

  // The STOP_CHK edge, optionally with a coincident acknowledge
  task automatic commit(input logic stop, input logic clr);
    rx_if.clr_rdy = clr;
    hold_bit(stop, 1);
    rx_if.clr_rdy = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rx_data"}, {8'h00, rx_if.rx_data}, 16'h0000);
    check({tag, "_rdy"},     {15'b0, rx_if.rdy}, 16'h0000);
    check({tag, "_ferr"},    {15'b0, rx_if.framing_err}, 16'h0000);
    check({tag, "_busy"},    {15'b0, rx_if.busy}, 16'h0000);
  endtask

  task automatic report(input string what);
    $display("%s: rx_data=%h rdy=%b framing_err=%b busy=%b", what,
             rx_if.rx_data, rx_if.rdy, rx_if.framing_err, rx_if.busy);
  endtask

  initial begin
    logic [7:0] v55;
    v55              = 8'h55;
    rst              = 1'b1;
    rx_if.start_edge = 1'b0;
    rx_if.rx_synch   = 1'b1;
    rx_if.clr_rdy    = 1'b0;
    line_prev        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    // Idle line for 500 cycles: nothing moves
    for (int i = 0; i < 500; i++) begin
      hold_bit(1'b1, 1);
      check("idle", {rx_if.rx_data, 5'b0, rx_if.rdy, rx_if.framing_err, rx_if.busy}, 16'h0000);
    end
    report("idle 500 cycles");

    // Good frame A5
    frame_body(8'hA5, 1'b1);
    check("a5_pre_rdy",  {15'b0, rx_if.rdy}, 16'h0000);
    check("a5_pre_busy", {15'b0, rx_if.busy}, 16'h0001);
    commit(1'b1, 1'b0);
    check("a5_rdy",     {15'b0, rx_if.rdy}, 16'h0001);
    check("a5_data",    {8'h00, rx_if.rx_data}, 16'h00A5);
    check("a5_ferr",    {15'b0, rx_if.framing_err}, 16'h0000);
    check("a5_busy",    {15'b0, rx_if.busy}, 16'h0000);
    report("frame A5 stop=1");
    hold_bit(1'b1, 5);

    // 3-cycle glitch: false start detected at the start-bit sample
    hold_bit(1'b1, 10);
    hold_bit(1'b0, 3);
    hold_bit(1'b1, 6);
    check("glitch_busy_pre", {15'b0, rx_if.busy}, 16'h0001);
    hold_bit(1'b1, 1);
    check("glitch_busy",  {15'b0, rx_if.busy}, 16'h0000);
    check("glitch_rdy",   {15'b0, rx_if.rdy}, 16'h0001);
    check("glitch_ferr",  {15'b0, rx_if.framing_err}, 16'h0000);
    check("glitch_data",  {8'h00, rx_if.rx_data}, 16'h00A5);
    report("glitch false start");

    rx_if.clr_rdy = 1'b1;
    hold_bit(1'b1, 1);
    rx_if.clr_rdy = 1'b0;
    check("clr_rdy",      {15'b0, rx_if.rdy}, 16'h0000);
    check("clr_keep",     {8'h00, rx_if.rx_data}, 16'h00A5);
    report("clr_rdy pulse");

    // Frame 3C with a bad stop bit
    frame_body(8'h3C, 1'b0);
    commit(1'b0, 1'b0);
    check("3c_ferr", {15'b0, rx_if.framing_err}, 16'h0001);
    check("3c_rdy",  {15'b0, rx_if.rdy}, 16'h0000);
    check("3c_data", {8'h00, rx_if.rx_data}, 16'h00A5);
    check("3c_busy", {15'b0, rx_if.busy}, 16'h0000);
    report("frame 3C stop=0");
    hold_bit(1'b0, 5);
    hold_bit(1'b1, 20);
    check("3c_ferr_sticky", {15'b0, rx_if.framing_err}, 16'h0001);
    rx_if.clr_rdy = 1'b1;
    hold_bit(1'b1, 1);
    rx_if.clr_rdy = 1'b0;
    check("ferr_clr", {15'b0, rx_if.framing_err}, 16'h0000);
    report("clr framing_err");

    // Back-to-back 01 then FF, acknowledge colliding with the second commit
    hold_bit(1'b1, 10);
    frame_body(8'h01, 1'b1);
    commit(1'b1, 1'b0);
    check("b2b1_rdy",  {15'b0, rx_if.rdy}, 16'h0001);
    check("b2b1_data", {8'h00, rx_if.rx_data}, 16'h0001);
    report("frame 01 stop=1");
    hold_bit(1'b1, 5);
    frame_body(8'hFF, 1'b1);
    check("b2b2_pre_rdy", {15'b0, rx_if.rdy}, 16'h0001);
    commit(1'b1, 1'b1);
    check("b2b2_rdy",  {15'b0, rx_if.rdy}, 16'h0001);
    check("b2b2_data", {8'h00, rx_if.rx_data}, 16'h00FF);
    check("b2b2_ferr", {15'b0, rx_if.framing_err}, 16'h0000);
    report("frame FF stop=1 with clr_rdy");
    hold_bit(1'b1, 5);
    check("b2b2_rdy_hold", {15'b0, rx_if.rdy}, 16'h0001);

    // Reset in the middle of data bit 4 of 55
    hold_bit(1'b1, 10);
    hold_bit(1'b0, BD);
    for (int k = 0; k < 4; k++) hold_bit(v55[k], BD);
    hold_bit(v55[4], 8);
    rst = 1'b1;
    hold_bit(v55[4], 1);
    rst = 1'b0;
    check_reset_state("midrst");
    report("reset mid-frame");
    hold_bit(1'b1, 40);
    frame_body(8'h55, 1'b1);
    commit(1'b1, 1'b0);
    check("55_rdy",  {15'b0, rx_if.rdy}, 16'h0001);
    check("55_data", {8'h00, rx_if.rx_data}, 16'h0055);
    check("55_ferr", {15'b0, rx_if.framing_err}, 16'h0000);
    report("frame 55 stop=1");
    hold_bit(1'b1, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Serial receive engine that sits directly downstream of the falling-edge synchronizer/detector on the UART RX pin. It uses the detector's one-cycle falling-edge pulse as the start-of-frame trigger. It then samples the already-synchronized serial line at mid-bit points and assembles an 8N1 frame into a parallel byte. The result is presented with a sticky ready flag for the consuming logic.

## Interface
- BAUD_DIV, default 2604: clocks per bit period (50 MHz / 19200 baud); legal range 4..65535.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start_edge  input  1  one-cycle pulse from the upstream falling-edge detector.
- rx_synch  input  1  serial line after the upstream double-flop; idle high.
- clr_rdy  input  1  consumer acknowledge; clears rdy and framing_err.
- rx_data  output  8  last correctly framed byte, LSB received first.
- rdy  output  1  sticky flag: new byte available in rx_data.
- framing_err  output  1  sticky flag: last frame had stop bit = 0.
- busy  output  1  high while a frame is being received.

## Operation
- Reset: state IDLE; rx_data=8'h00, rdy=0, framing_err=0, busy=0; baud counter and bit index = 0.
- States:
  - IDLE: wait for start_edge.
  - RX: sample bits.
  - STOP_CHK: one cycle to commit or flag the frame.
- IDLE -> RX on start_edge:
  - load baud counter with BAUD_DIV/2 (integer divide) to align to the first mid-bit;
  - bit index = 0;
  - busy = 1;
  - framing_err is cleared.
- RX behaviour:
  - The counter decrements every clock. At 0 it samples rx_synch, reloads BAUD_DIV-1, and increments the bit index.
  - Bit index 0 is the start bit. If it samples 1, this is a false start: go to IDLE, busy=0, no flags change.
  - Bit indexes 1..8 are data bits, shifted into a 9-bit shift register LSB-first.
  - Bit index 9 is the stop bit. Sample it, then go to STOP_CHK.
- STOP_CHK:
  - Stop bit = 1: rx_data <= shifted byte; rdy <= 1.
  - Stop bit = 0: framing_err <= 1; rx_data and rdy unchanged.
  - In both cases -> IDLE, busy=0.
- The shift register is internal. rx_data changes only on a good frame commit.
- start_edge while not in IDLE is ignored. Upstream edges from data bits are expected.
- If rdy is still 1 when a new good frame commits, rx_data is overwritten and rdy stays 1 (overrun is not flagged).
- Simultaneous clr_rdy and a commit in the same cycle: the commit wins, so rdy=1 or framing_err=1 afterwards.
- Reset asserted mid-frame: next cycle is the reset state. The partial byte is discarded.

## Timing
- start_edge sampled high at cycle T.
- Start-bit sample at T+1+BAUD_DIV/2.
- Data bit k (k=0..7) sampled at T+1+BAUD_DIV/2+(k+1)*BAUD_DIV.
- Stop bit sampled at T+1+BAUD_DIV/2+9*BAUD_DIV.
- rdy/framing_err/rx_data update one cycle after the stop sample (STOP_CHK), visible the following cycle.
- busy is high from T+1 through the STOP_CHK cycle inclusive.
- Earliest re-arm: start_edge accepted on the first IDLE cycle after STOP_CHK.
- The baud counter is a 16-bit unsigned down-counter and never wraps; reload occurs exactly at 0.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Shared package uart_pkg:
  - rx_state_t enum {IDLE, RX, STOP_CHK};
  - FRAME_BITS=10;
  - DATA_BITS=8;
  - default BAUD_DIV constant.
- One sub-module, baud_cnt: loadable 16-bit down-counter with load value input and a zero-strobe output. It is reusable by the planned TX block.
- The upstream synchronizer/edge detector is instantiated by the parent, not inside this block.

## Test plan
- Reset then idle line, BAUD_DIV=16:
  - required: rdy=0, framing_err=0, busy=0, rx_data=8'h00 for 500 cycles.
- Good frame 8'hA5 at 16 clk/bit:
  - required: rdy rises 1 cycle after the stop sample, rx_data=8'hA5, framing_err=0;
  - clr_rdy pulse -> rdy=0 next cycle.
- Frame 8'h3C with stop bit driven 0:
  - required: framing_err=1, rdy=0, rx_data keeps its previous value.
- 3-cycle low glitch then line high:
  - required: false start; busy drops after the start sample, no flag changes.
- Back-to-back frames 8'h01, 8'hFF with no idle gap and no clr_rdy:
  - required: rdy stays 1, rx_data=8'hFF at end;
  - clr_rdy coinciding with the second commit -> rdy=1.
- rst asserted at data bit 4 of frame 8'h55:
  - required: reset state next cycle;
  - a following 8'h55 frame is received correctly.
